// File: rtl/elevator_call_scheduler_if.sv
// ---------------------------------------------------------------------------
// elevator_call_scheduler_if
//   Bundle between the call scheduler and its environment (buttons, floor
//   sensor and the downstream elevator FSM).
//
//   call_btn     : level call request per floor (bit i requests floor i)
//   floor_arrive : one-cycle floor-sensor pulse
//   arrive_floor : floor index qualified by floor_arrive
//   upDown       : direction command to the FSM (00 stop, 01 up, 10 down)
//   cur_floor    : last floor reached
//   pending      : latched outstanding calls
//   door_open    : high while dwelling at a floor
//
//   master : environment side (drives buttons / sensor, observes commands)
//   slave  : scheduler side
// ---------------------------------------------------------------------------
interface elevator_call_scheduler_if #(
   parameter int N_FLOORS = 4,
   parameter int FLOOR_W  = 2
);
   logic [N_FLOORS-1:0] call_btn;
   logic                floor_arrive;
   logic [FLOOR_W-1:0]  arrive_floor;
   logic [1:0]          upDown;
   logic [FLOOR_W-1:0]  cur_floor;
   logic [N_FLOORS-1:0] pending;
   logic                door_open;

   modport master (
      output call_btn, floor_arrive, arrive_floor,
      input  upDown, cur_floor, pending, door_open
   );

   modport slave (
      input  call_btn, floor_arrive, arrive_floor,
      output upDown, cur_floor, pending, door_open
   );
endinterface

// File: rtl/elevator_call_scheduler.sv
// ---------------------------------------------------------------------------
// elevator_call_scheduler
//   Latches floor calls, tracks the current floor and issues the 2-bit
//   direction command for the elevator FSM using a SCAN policy: keep going
//   while calls remain ahead, dwell with the door open at each called floor,
//   then continue, reverse or go idle.
//
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : elevator_call_scheduler_if.slave
//             in  call_btn, floor_arrive, arrive_floor
//             out upDown, cur_floor, pending, door_open (all registered)
// ---------------------------------------------------------------------------
module elevator_call_scheduler #(
   parameter int N_FLOORS     = 4,
   parameter int FLOOR_W      = 2,
   parameter int DWELL_CYCLES = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   elevator_call_scheduler_if.slave    bus
);

   localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

   localparam logic [1:0] CMD_STOP = 2'b00;
   localparam logic [1:0] CMD_UP   = 2'b01;
   localparam logic [1:0] CMD_DOWN = 2'b10;

   typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DWELL} state_t;
   typedef enum logic       {DIR_UP, DIR_DOWN} dir_t;

   state_t              state;
   dir_t                dir_last;
   logic [CNT_W-1:0]    dwell_cnt;
   logic [N_FLOORS-1:0] pending_q;
   logic [FLOOR_W-1:0]  cur_floor_q;
   logic [1:0]          up_down_q;
   logic                door_open_q;

   assign bus.pending   = pending_q;
   assign bus.cur_floor = cur_floor_q;
   assign bus.upDown    = up_down_q;
   assign bus.door_open = door_open_q;

   // One-hot mask selecting floor f.
   function automatic logic [N_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
      floor_mask = '0;
      for (int i = 0; i < N_FLOORS; i++)
         if (i == int'(f)) floor_mask[i] = 1'b1;
   endfunction

   // Mask of all floors strictly above f.
   function automatic logic [N_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
      above_mask = '0;
      for (int i = 0; i < N_FLOORS; i++)
         if (i > int'(f)) above_mask[i] = 1'b1;
   endfunction

   // Mask of all floors strictly below f.
   function automatic logic [N_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
      below_mask = '0;
      for (int i = 0; i < N_FLOORS; i++)
         if (i < int'(f)) below_mask[i] = 1'b1;
   endfunction

   logic [N_FLOORS-1:0] cur_mask;
   logic [N_FLOORS-1:0] arr_mask;
   logic [N_FLOORS-1:0] set_mask;
   logic                above_cur;
   logic                below_cur;
   logic                here_cur;
   logic                arr_valid;
   logic                arr_hit;
   logic                arr_above;
   logic                arr_below;
   logic                door_hold;

   // NOTE: every signal is assigned on every path through this block, so no
   // latch can be inferred; add a default first if a branch is ever added.
   always_comb begin
      cur_mask  = floor_mask(cur_floor_q);
      arr_mask  = floor_mask(bus.arrive_floor);
      above_cur = |(pending_q & above_mask(cur_floor_q));
      below_cur = |(pending_q & below_mask(cur_floor_q));
      here_cur  = |((pending_q | bus.call_btn) & cur_mask);
      arr_valid = bus.floor_arrive && (int'(bus.arrive_floor) < N_FLOORS);
      arr_hit   = |((pending_q | bus.call_btn) & arr_mask);
      arr_above = |(pending_q & above_mask(bus.arrive_floor));
      arr_below = |(pending_q & below_mask(bus.arrive_floor));
      // A press of the floor we are dwelling at holds the door instead of
      // becoming a new call.
      door_hold = |(bus.call_btn & cur_mask);
      set_mask  = (state == DWELL) ? (bus.call_btn & ~cur_mask) : bus.call_btn;
   end

   // NOTE: all state is updated with non-blocking assignments so every
   // register sees the pre-edge values of the others; later assignments in
   // the same branch override earlier defaults (used for pending clear).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         dir_last    <= DIR_UP;
         dwell_cnt   <= '0;
         pending_q   <= '0;
         cur_floor_q <= '0;
         up_down_q   <= CMD_STOP;
         door_open_q <= 1'b0;
      end else begin
         pending_q <= pending_q | set_mask;

         case (state)
            IDLE: begin
               if (here_cur) begin
                  state       <= DWELL;
                  up_down_q   <= CMD_STOP;
                  door_open_q <= 1'b1;
                  dwell_cnt   <= DWELL_LOAD;
                  pending_q   <= (pending_q | set_mask) & ~cur_mask;
               end else if (above_cur) begin
                  state     <= MOVE_UP;
                  up_down_q <= CMD_UP;
                  dir_last  <= DIR_UP;
               end else if (below_cur) begin
                  state     <= MOVE_DOWN;
                  up_down_q <= CMD_DOWN;
                  dir_last  <= DIR_DOWN;
               end
            end

            MOVE_UP, MOVE_DOWN: begin
               if (arr_valid) begin
                  cur_floor_q <= bus.arrive_floor;
                  if (arr_hit) begin
                     state       <= DWELL;
                     up_down_q   <= CMD_STOP;
                     door_open_q <= 1'b1;
                     dwell_cnt   <= DWELL_LOAD;
                     pending_q   <= (pending_q | set_mask) & ~arr_mask;
                  end else if (state == MOVE_UP && !arr_above) begin
                     // Nothing left ahead: same decision IDLE would take.
                     if (arr_below) begin
                        state     <= MOVE_DOWN;
                        up_down_q <= CMD_DOWN;
                        dir_last  <= DIR_DOWN;
                     end else begin
                        state     <= IDLE;
                        up_down_q <= CMD_STOP;
                     end
                  end else if (state == MOVE_DOWN && !arr_below) begin
                     if (arr_above) begin
                        state     <= MOVE_UP;
                        up_down_q <= CMD_UP;
                        dir_last  <= DIR_UP;
                     end else begin
                        state     <= IDLE;
                        up_down_q <= CMD_STOP;
                     end
                  end
               end
            end

            DWELL: begin
               if (door_hold) begin
                  dwell_cnt <= DWELL_LOAD;
               end else if (dwell_cnt != '0) begin
                  dwell_cnt <= dwell_cnt - CNT_W'(1);
               end else begin
                  door_open_q <= 1'b0;
                  // Prefer continuing in the last travel direction.
                  if (dir_last == DIR_UP) begin
                     if (above_cur) begin
                        state     <= MOVE_UP;
                        up_down_q <= CMD_UP;
                        dir_last  <= DIR_UP;
                     end else if (below_cur) begin
                        state     <= MOVE_DOWN;
                        up_down_q <= CMD_DOWN;
                        dir_last  <= DIR_DOWN;
                     end else begin
                        state     <= IDLE;
                        up_down_q <= CMD_STOP;
                     end
                  end else begin
                     if (below_cur) begin
                        state     <= MOVE_DOWN;
                        up_down_q <= CMD_DOWN;
                        dir_last  <= DIR_DOWN;
                     end else if (above_cur) begin
                        state     <= MOVE_UP;
                        up_down_q <= CMD_UP;
                        dir_last  <= DIR_UP;
                     end else begin
                        state     <= IDLE;
                        up_down_q <= CMD_STOP;
                     end
                  end
               end
            end

            default: begin
               state     <= IDLE;
               up_down_q <= CMD_STOP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// ---------------------------------------------------------------------------
// tb_elevator_call_scheduler
//   Directed bench for elevator_call_scheduler. A floor-level reference model
//   (mode + pending set + remaining door cycles) predicts the outputs; a
//   compare process checks them every falling edge, and directed scenarios
//   add literal expectations.
// ---------------------------------------------------------------------------
module tb_elevator_call_scheduler;

   localparam int NF = 4;
   localparam int FW = 3;   // wide enough to present an out-of-range floor
   localparam int DW = 8;

   logic clk;
   logic rst_n;

   elevator_call_scheduler_if #(.N_FLOORS(NF), .FLOOR_W(FW)) bus ();

   elevator_call_scheduler #(
      .N_FLOORS    (NF),
      .FLOOR_W     (FW),
      .DWELL_CYCLES(DW)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_UP, M_DOWN, M_DWELL} mode_t;

   mode_t        m_mode;
   int           m_floor;
   bit [NF-1:0]  m_pend;
   int           m_left;
   bit           m_pref_down;

   function automatic bit calls_above(input bit [NF-1:0] p, input int f);
      for (int i = f + 1; i < NF; i++) if (p[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit calls_below(input bit [NF-1:0] p, input int f);
      for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      mode_t       mode;
      int          fl;
      int          left;
      bit          pref_down;
      bit [NF-1:0] p_old;
      bit [NF-1:0] p;
      bit [NF-1:0] cb;
      int          af;
      if (!rst_n) begin
         m_mode      <= M_IDLE;
         m_floor     <= 0;
         m_pend      <= '0;
         m_left      <= 0;
         m_pref_down <= 1'b0;
      end else begin
         mode      = m_mode;
         fl        = m_floor;
         left      = m_left;
         pref_down = m_pref_down;
         p_old     = m_pend;
         cb        = bus.call_btn;
         af        = int'(bus.arrive_floor);
         p         = p_old | cb;
         case (mode)
            M_IDLE: begin
               if (p_old[fl] || cb[fl]) begin
                  mode = M_DWELL; left = DW; p[fl] = 1'b0;
               end else if (calls_above(p_old, fl)) begin
                  mode = M_UP; pref_down = 1'b0;
               end else if (calls_below(p_old, fl)) begin
                  mode = M_DOWN; pref_down = 1'b1;
               end
            end
            M_UP, M_DOWN: begin
               if (bus.floor_arrive && af < NF) begin
                  fl = af;
                  if (p_old[fl] || cb[fl]) begin
                     mode = M_DWELL; left = DW; p[fl] = 1'b0;
                  end else if ((mode == M_UP)   ? !calls_above(p_old, fl)
                                                : !calls_below(p_old, fl)) begin
                     if (calls_above(p_old, fl)) begin
                        mode = M_UP; pref_down = 1'b0;
                     end else if (calls_below(p_old, fl)) begin
                        mode = M_DOWN; pref_down = 1'b1;
                     end else begin
                        mode = M_IDLE;
                     end
                  end
               end
            end
            M_DWELL: begin
               p[fl] = p_old[fl];
               if (cb[fl]) begin
                  left = DW;
               end else begin
                  left = left - 1;
                  if (left == 0) begin
                     if (!pref_down && calls_above(p_old, fl))      mode = M_UP;
                     else if (pref_down && calls_below(p_old, fl))  mode = M_DOWN;
                     else if (calls_above(p_old, fl))               mode = M_UP;
                     else if (calls_below(p_old, fl))               mode = M_DOWN;
                     else                                           mode = M_IDLE;
                     if (mode == M_UP)   pref_down = 1'b0;
                     if (mode == M_DOWN) pref_down = 1'b1;
                  end
               end
            end
            default: mode = M_IDLE;
         endcase
         m_mode      <= mode;
         m_floor     <= fl;
         m_pend      <= p;
         m_left      <= left;
         m_pref_down <= pref_down;
      end
   end

   function automatic logic [1:0] exp_cmd(input mode_t m);
      if (m == M_UP)   return 2'b01;
      if (m == M_DOWN) return 2'b10;
      return 2'b00;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         check("cmp_upDown",    32'(bus.upDown),    32'(exp_cmd(m_mode)));
         check("cmp_door_open", 32'(bus.door_open), 32'(m_mode == M_DWELL));
         check("cmp_cur_floor", 32'(bus.cur_floor), 32'(m_floor));
         check("cmp_pending",   32'(bus.pending),   32'(m_pend));
         check("cmp_not_11",    32'(bus.upDown == 2'b11), 32'(0));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input logic [NF-1:0] v);
      bus.call_btn = v;
      cyc(1);
      bus.call_btn = '0;
   endtask

   task automatic arrive(input int f);
      bus.floor_arrive = 1'b1;
      bus.arrive_floor = FW'(f);
      cyc(1);
      bus.floor_arrive = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      cyc(1);
   endtask

   // Counts door_open-high samples until the door closes (bounded).
   task automatic count_door(output int n);
      bit done;
      n    = 0;
      done = 1'b0;
      for (int k = 0; k < 64 && !done; k++) begin
         if (bus.door_open) n++;
         else if (n > 0) done = 1'b1;
         if (!done) cyc(1);
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL door_timeout: door still open or never opened after 64 cycles at %0t", $time);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int n;
      rst_n            = 1'b0;
      bus.call_btn     = '0;
      bus.floor_arrive = 1'b0;
      bus.arrive_floor = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_upDown",    32'(bus.upDown),    32'(0));
      check("rst_pending",   32'(bus.pending),   32'(0));
      check("rst_cur_floor", 32'(bus.cur_floor), 32'(0));
      check("rst_door_open", 32'(bus.door_open), 32'(0));
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      cyc(1);

      // 1: single call to the top floor
      press(4'b1000);
      check("t1_pending_latched", 32'(bus.pending), 32'h8);
      check("t1_upDown_still_00", 32'(bus.upDown),  32'(0));
      cyc(1);
      check("t1_upDown_up", 32'(bus.upDown), 32'(1));
      arrive(1);
      check("t1_floor1", 32'(bus.cur_floor), 32'(1));
      arrive(2);
      arrive(3);
      check("t1_floor3",  32'(bus.cur_floor), 32'(3));
      check("t1_stop",    32'(bus.upDown),    32'(0));
      check("t1_door",    32'(bus.door_open), 32'(1));
      check("t1_cleared", 32'(bus.pending),   32'(0));
      count_door(n);
      check("t1_dwell_len", 32'(n), 32'(8));
      check("t1_idle", 32'(bus.upDown), 32'(0));

      // 2: going up at floor 1, calls at 3 and 0
      do_reset();
      press(4'b1000);
      cyc(1);
      arrive(1);
      press(4'b1001);
      check("t2_pending", 32'(bus.pending), 32'h9);
      arrive(2);
      arrive(3);
      check("t2_stop3_pending", 32'(bus.pending), 32'h1);
      count_door(n);
      check("t2_dwell3", 32'(n), 32'(8));
      check("t2_reverse", 32'(bus.upDown), 32'(2));
      arrive(2);
      arrive(1);
      arrive(0);
      check("t2_floor0", 32'(bus.cur_floor), 32'(0));
      check("t2_door0",  32'(bus.door_open), 32'(1));
      count_door(n);
      check("t2_dwell0", 32'(n), 32'(8));
      check("t2_idle", 32'(bus.upDown), 32'(0));

      // 3: call for the current floor while idle
      press(4'b0100);
      cyc(1);
      arrive(1);
      arrive(2);
      count_door(n);
      press(4'b0100);
      check("t3_door",    32'(bus.door_open), 32'(1));
      check("t3_stop",    32'(bus.upDown),    32'(0));
      check("t3_pending", 32'(bus.pending),   32'(0));
      check("t3_floor",   32'(bus.cur_floor), 32'(2));
      count_door(n);
      check("t3_dwell", 32'(n), 32'(8));

      // 4: door held by a press on dwell cycle 5
      press(4'b0100);
      cyc(4);
      bus.call_btn = 4'b0100;
      cyc(1);
      bus.call_btn = '0;
      check("t4_no_pending", 32'(bus.pending), 32'(0));
      count_door(n);
      check("t4_door_hold", 32'(5 + n), 32'(13));

      // 5: calls both sides from idle at floor 1 -> up wins
      press(4'b0010);
      cyc(1);
      check("t5_down", 32'(bus.upDown), 32'(2));
      arrive(1);
      count_door(n);
      press(4'b1001);
      check("t5_pending", 32'(bus.pending), 32'h9);
      cyc(1);
      check("t5_above_wins", 32'(bus.upDown), 32'(1));

      // 6: out-of-range arrival while moving, arrival while idle
      arrive(5);
      check("t6_oor_floor", 32'(bus.cur_floor), 32'(1));
      check("t6_oor_dir",   32'(bus.upDown),    32'(1));
      arrive(2);
      arrive(3);
      count_door(n);
      check("t6_reverse", 32'(bus.upDown), 32'(2));
      arrive(2);
      arrive(1);
      arrive(0);
      count_door(n);
      arrive(3);
      check("t6_idle_arrive_floor", 32'(bus.cur_floor), 32'(0));
      check("t6_idle_arrive_dir",   32'(bus.upDown),    32'(0));

      // 7: asynchronous reset mid-move and mid-dwell
      press(4'b1000);
      cyc(1);
      arrive(1);
      check("t7_moving", 32'(bus.upDown), 32'(1));
      rst_n = 1'b0;
      #2;
      check("t7_rst_upDown",  32'(bus.upDown),    32'(0));
      check("t7_rst_pending", 32'(bus.pending),   32'(0));
      check("t7_rst_floor",   32'(bus.cur_floor), 32'(0));
      rst_n = 1'b1;
      cyc(1);
      press(4'b0001);
      cyc(2);
      check("t7_dwelling", 32'(bus.door_open), 32'(1));
      rst_n = 1'b0;
      #2;
      check("t7_rst_door", 32'(bus.door_open), 32'(0));
      rst_n = 1'b1;
      cyc(3);

      cmp_en = 1'b0;
      cyc(1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
- Upstream neighbour of the elevator FSM: latches floor-call buttons, tracks the current floor and produces the 2-bit `upDown` direction command the FSM consumes.
- Uses a SCAN (elevator) policy: keep moving in the current direction while calls remain ahead, dwell at each called floor with the door open, then reverse or go idle.

Parameters:
- N_FLOORS, 4, number of floors served (2..16).
- FLOOR_W, 2, width of floor indices; must satisfy 2^FLOOR_W >= N_FLOORS.
- DWELL_CYCLES, 8, clock cycles `door_open` stays high per stop (>=1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- call_btn  in  N_FLOORS  level call request per floor; bit i high in a cycle requests floor i.
- floor_arrive  in  1  one-cycle pulse from the floor sensor when the car reaches a floor.
- arrive_floor  in  FLOOR_W  floor index qualified by floor_arrive.
- upDown  out  2  direction command to FSM: 00 stop, 01 up, 10 down; 11 never driven.
- cur_floor  out  FLOOR_W  last floor reached.
- pending  out  N_FLOORS  latched outstanding calls.
- door_open  out  1  high while dwelling at a floor.

Behaviour:
- Reset (async assert, sync-safe release):
  - state=IDLE, pending=0, cur_floor=0, upDown=00, door_open=0, dwell counter=0, dir_last=UP.
- Call latching:
  - pending[i] <= 1 on any cycle with call_btn[i]=1.
  - A bit is cleared only on the cycle the car enters DWELL at floor i.
  - Set and clear in the same cycle for the same floor: clear wins, unless the call is for a floor other than the stop floor.
- Internal signals:
  - above = |pending bits > cur_floor.
  - below = |pending bits < cur_floor.
  - here = pending[cur_floor] | call_btn[cur_floor].
- States: IDLE, MOVE_UP, MOVE_DOWN, DWELL. All outputs are registered.
  - IDLE:
    - here -> DWELL.
    - else above -> MOVE_UP; above wins if both above and below.
    - else below -> MOVE_DOWN.
    - else stay.
  - MOVE_UP / MOVE_DOWN:
    - upDown = 01 / 10.
    - On floor_arrive with arrive_floor < N_FLOORS: cur_floor <= arrive_floor.
      - If pending[arrive_floor] or call_btn[arrive_floor] -> DWELL.
      - Else if no pending calls remain in the travel direction -> re-evaluate as IDLE in the same cycle.
    - floor_arrive with out-of-range arrive_floor is ignored.
    - floor_arrive in IDLE or DWELL is ignored.
  - DWELL:
    - upDown = 00, door_open = 1, counter loads DWELL_CYCLES-1 on entry.
    - Exit after exactly DWELL_CYCLES cycles of door_open.
    - A call_btn for cur_floor during DWELL reloads the counter (door held) and does not set pending.
    - On exit, direction preference = dir_last:
      - UP: above -> MOVE_UP, else below -> MOVE_DOWN, else IDLE.
      - DOWN: mirrored.
- dir_last: updated to UP/DOWN on every entry to MOVE_UP/MOVE_DOWN.
- Latency:
  - call_btn to pending: 1 cycle.
  - IDLE decision to upDown change: 1 cycle after pending is visible. A call in IDLE at cycle t produces upDown at t+2.
- Boundaries:
  - At the top floor in MOVE_UP, above=0 by construction, so the block reverses or idles.
  - At floor 0 in MOVE_DOWN: mirrored.
  - upDown is never 11.
  - A mid-operation reset immediately forces upDown=00 and door_open=0 and drops all pending calls.

Test Plan:
- Reset, then call_btn=4'b1000 for 1 cycle -> pending=1000 next cycle; upDown=01 one cycle later. Pulse arrive at 1, 2, 3 -> at 3: cur_floor=3, upDown=00, door_open high 8 cycles, pending=0000, then IDLE.
- At floor 1 going up, calls at floors 3 and 0 -> stops at 3 first (dwell 8), then upDown=10, stops at 0; dir_last ends DOWN.
- In IDLE at floor 2, call_btn[2] -> DWELL directly; upDown stays 00; door_open=1 for 8 cycles.
- During DWELL at floor 2, call_btn[2] pulsed on dwell cycle 5 -> door_open extends to 5+8 total cycles; pending[2] stays 0.
- Calls at floors 0 and 3 simultaneously from IDLE at floor 1 -> MOVE_UP chosen (above wins).
- floor_arrive with arrive_floor=3 while IDLE, and arrive_floor=5 with N_FLOORS=4 while moving -> cur_floor unchanged in both cases.
- Assert rst_n=0 mid-move -> upDown=00, pending=0, cur_floor=0 asynchronously.
